// File: rtl/mpu_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mpu_core: multi-cycle micro-processor (FETCH/WAIT/EXEC/HALT), 32-bit ISA     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module mpu_core #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int PCW  = 13
) (
  input  logic           sys_clk,
  input  logic           sys_res,
  input  logic           en,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic [31:0]    imem_data,
  input  logic           imem_vld,
  output logic [DW-1:0]  io_out,
  output logic           io_vld,
  output logic           halted,
  output logic           err
);

  localparam logic [4:0] C_NREG = 5'(NREG);

  typedef enum logic [1:0] {S_FETCH = 2'd0, S_WAIT = 2'd1, S_EXEC = 2'd2, S_HALT = 2'd3} state_t;

  state_t         r_state, w_next;
  logic [PCW-1:0] r_pc;
  logic [31:0]    r_ir;
  logic [DW-1:0]  r_io_out;
  logic           r_io_vld;
  logic           r_err;
  // Indexed by the full 4-bit field; entries at or above NREG are never written.
  logic [DW-1:0]  r_regs [16];

  logic           w_req;
  logic [3:0]     w_op, w_rd, w_rs1, w_rs2;
  logic           w_rd_ok, w_rs1_ok, w_rs2_ok;
  logic [DW-1:0]  w_a, w_b, w_imm_d, w_wdata;
  logic [PCW-1:0] w_imm_pc, w_pc_next;
  logic           w_wr, w_jmp, w_out, w_bad;

  assign w_op     = r_ir[31:28];
  assign w_rd     = r_ir[27:24];
  assign w_rs1    = r_ir[23:20];
  assign w_rs2    = r_ir[19:16];
  assign w_imm_d  = r_ir[DW-1:0];
  assign w_imm_pc = r_ir[PCW-1:0];
  assign w_rd_ok  = {1'b0, w_rd}  < C_NREG;
  assign w_rs1_ok = {1'b0, w_rs1} < C_NREG;
  assign w_rs2_ok = {1'b0, w_rs2} < C_NREG;
  assign w_a      = r_regs[w_rs1];
  assign w_b      = r_regs[w_rs2];

  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    case (r_state)
      S_FETCH: if (en) begin
        w_req  = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT:  if (imem_vld) w_next = S_EXEC;
      S_EXEC:  w_next = (w_op == 4'hF) ? S_HALT : S_FETCH;
      default: w_next = S_HALT;
    endcase
  end

  always_comb begin
    w_wr    = 1'b0;
    w_wdata = '0;
    w_jmp   = 1'b0;
    w_out   = 1'b0;
    w_bad   = 1'b0;
    case (w_op)
      4'h0, 4'hF: ;
      4'h1: begin
        w_wdata = w_imm_d;
        w_wr    = w_rd_ok;
        w_bad   = !w_rd_ok;
      end
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        case (w_op)
          4'h2:    w_wdata = w_a + w_b;
          4'h3:    w_wdata = w_a - w_b;
          4'h4:    w_wdata = w_a & w_b;
          4'h5:    w_wdata = w_a | w_b;
          default: w_wdata = w_a ^ w_b;
        endcase
        w_wr  = w_rd_ok && w_rs1_ok && w_rs2_ok;
        w_bad = !w_wr;
      end
      4'h7: w_jmp = 1'b1;
      4'h8: begin
        w_jmp = w_rs1_ok && (w_a == '0);
        w_bad = !w_rs1_ok;
      end
      4'h9: begin
        w_out = w_rs1_ok;
        w_bad = !w_rs1_ok;
      end
      default: w_bad = 1'b1;
    endcase
  end

  assign w_pc_next = w_jmp ? w_imm_pc : r_pc + 1'b1;

  always_ff @(posedge sys_clk or posedge sys_res) begin
    if (sys_res) begin
      r_state  <= S_FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_io_out <= '0;
      r_io_vld <= 1'b0;
      r_err    <= 1'b0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      r_state  <= w_next;
      r_io_vld <= 1'b0;
      if (r_state == S_WAIT && imem_vld) r_ir <= imem_data;
      if (r_state == S_EXEC) begin
        r_pc <= w_pc_next;
        if (w_wr)  r_regs[w_rd] <= w_wdata;
        if (w_out) begin
          r_io_out <= w_a;
          r_io_vld <= 1'b1;
        end
        if (w_bad) r_err <= 1'b1;
      end
    end
  end

  // The FETCH request is combinational, so mask it while reset is held.
  assign imem_req  = w_req && !sys_res;
  assign imem_addr = r_pc;
  assign io_out    = r_io_out;
  assign io_vld    = r_io_vld;
  assign halted    = (r_state == S_HALT);
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mpu_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mpu_core: directed self-checking bench for mpu_core                       |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_mpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        imem_req;
  logic [12:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic        imem_vld  = 1'b0;
  logic [7:0]  io_out;
  logic        io_vld;
  logic        halted;
  logic        err;

  mpu_core #(.DW(8), .NREG(8), .PCW(13)) dut (
    .sys_clk(clk), .sys_res(rst), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_vld(imem_vld),
    .io_out(io_out), .io_vld(io_vld), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          lat   = 1;
  int          pend  = 0;
  logic        spur  = 1'b0;
  logic [31:0] rdata;
  logic [31:0] mem [8192];
  int          reqq [$];
  int          reqc [$];
  int          outq [$];
  int          outc [$];
  int          nreq, nout;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data captured at request time, returned after lat cycles.
  always @(negedge clk) begin
    imem_vld = spur;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        imem_vld  = 1'b1;
        imem_data = rdata;
      end
    end
    if (imem_req) begin
      pend  = lat;
      rdata = mem[imem_addr];
    end
  end

  always @(negedge clk) begin
    if (imem_req) begin
      reqq.push_back(int'(imem_addr));
      reqc.push_back(cyc);
    end
    if (io_vld) begin
      outq.push_back(int'(io_out));
      outc.push_back(cyc);
    end
  end

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  function automatic int aq(input int i);
    return (i < reqq.size()) ? reqq[i] : -1;
  endfunction

  function automatic int oq(input int i);
    return (i < outq.size()) ? outq[i] : -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    reqq.delete(); reqc.delete(); outq.delete(); outc.delete();
  endtask

  task automatic load_clear();
    for (int i = 0; i < 8192; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    en  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic run_halt(input string tag);
    int n;
    n = 0;
    @(posedge clk); #2;
    en = 1'b1;
    while (!halted && n < 300) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk(tag, halted, 1'b1);
  endtask

  initial begin
    // Reset state, with en high so the FETCH request mask is exercised.
    load_clear();
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_io_out", io_out, 8'h00);
    chk("rst_io_vld", io_vld, 1'b0);
    chk("rst_addr", imem_addr, 13'h0);

    // Basic program and throughput.
    do_reset();
    mem[0] = ins(4'h1, 4'd1, 4'd0, 4'd0, 16'd5);
    mem[1] = ins(4'h1, 4'd2, 4'd0, 4'd0, 16'd3);
    mem[2] = ins(4'h2, 4'd3, 4'd1, 4'd2, 16'd0);
    mem[3] = ins(4'h9, 4'd0, 4'd3, 4'd0, 16'd0);
    mem[4] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    run_halt("p1_halt");
    chk("p1_out", oq(0), 8);
    chk("p1_nvld", outq.size(), 1);
    chk("p1_first_addr", aq(0), 0);
    chk("p1_latency", (outc.size() > 0 && reqc.size() > 0) ? outc[0] - reqc[0] : -1, 12);
    chk("p1_err", err, 1'b0);

    // Wrap arithmetic, logic ops, rd aliasing rs1.
    do_reset();
    load_clear();
    mem[0]  = ins(4'h1, 4'd1, 4'd0, 4'd0, 16'h00FF);
    mem[1]  = ins(4'h1, 4'd2, 4'd0, 4'd0, 16'h0001);
    mem[2]  = ins(4'h2, 4'd3, 4'd1, 4'd2, 16'd0);
    mem[3]  = ins(4'h3, 4'd4, 4'd3, 4'd2, 16'd0);
    mem[4]  = ins(4'h9, 4'd0, 4'd3, 4'd0, 16'd0);
    mem[5]  = ins(4'h9, 4'd0, 4'd4, 4'd0, 16'd0);
    mem[6]  = ins(4'h1, 4'd5, 4'd0, 4'd0, 16'h003C);
    mem[7]  = ins(4'h1, 4'd6, 4'd0, 4'd0, 16'h000F);
    mem[8]  = ins(4'h4, 4'd7, 4'd5, 4'd6, 16'd0);
    mem[9]  = ins(4'h5, 4'd1, 4'd5, 4'd6, 16'd0);
    mem[10] = ins(4'h6, 4'd5, 4'd5, 4'd6, 16'd0);
    mem[11] = ins(4'h9, 4'd0, 4'd7, 4'd0, 16'd0);
    mem[12] = ins(4'h9, 4'd0, 4'd1, 4'd0, 16'd0);
    mem[13] = ins(4'h9, 4'd0, 4'd5, 4'd0, 16'd0);
    mem[14] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    run_halt("p2_halt");
    chk("p2_add_wrap", oq(0), 8'h00);
    chk("p2_sub_wrap", oq(1), 8'hFF);
    chk("p2_and", oq(2), 8'h0C);
    chk("p2_or", oq(3), 8'h3F);
    chk("p2_xor_alias", oq(4), 8'h33);
    chk("p2_err", err, 1'b0);

    // BEQZ taken on R0, then not taken on a nonzero register.
    do_reset();
    load_clear();
    mem[0]     = ins(4'h1, 4'd1, 4'd0, 4'd0, 16'd1);
    mem[1]     = ins(4'h8, 4'd0, 4'd0, 4'd0, 16'h0010);
    mem[16'h10] = ins(4'h8, 4'd0, 4'd1, 4'd0, 16'h0020);
    mem[16'h11] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    run_halt("p3_halt");
    chk("p3_a1", aq(1), 1);
    chk("p3_taken", aq(2), 16'h10);
    chk("p3_not_taken", aq(3), 16'h11);

    // PC wrap at 2^PCW-1 and sticky err from an undefined opcode.
    do_reset();
    load_clear();
    mem[0]      = ins(4'h8, 4'd0, 4'd2, 4'd0, 16'h1FFE);
    mem[13'h1FFE] = ins(4'h1, 4'd2, 4'd0, 4'd0, 16'd1);
    mem[13'h1FFF] = ins(4'h0, 4'd0, 4'd0, 4'd0, 16'd0);
    mem[1]      = ins(4'hC, 4'd0, 4'd0, 4'd0, 16'd0);
    mem[2]      = ins(4'h0, 4'd0, 4'd0, 4'd0, 16'd0);
    mem[3]      = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    run_halt("p4_halt");
    chk("p4_at_top", aq(2), 13'h1FFF);
    chk("p4_wrap", aq(3), 0);
    chk("p4_op12_pc", aq(5), 2);
    chk("p4_err", err, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    chk("p4_err_sticky", err, 1'b1);

    // Out-of-range register index: write suppressed, err set, PC+1.
    do_reset();
    load_clear();
    chk("p5_err_cleared", err, 1'b0);
    mem[0] = ins(4'h1, 4'd1, 4'd0, 4'd0, 16'd7);
    mem[1] = ins(4'h1, 4'd9, 4'd0, 4'd0, 16'd3);
    mem[2] = ins(4'h9, 4'd0, 4'd1, 4'd0, 16'd0);
    mem[3] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    run_halt("p5_halt");
    chk("p5_out", oq(0), 7);
    chk("p5_pc_next", aq(2), 2);
    chk("p5_err", err, 1'b1);

    // HALT holds everything against en toggling and stray imem_vld.
    do_reset();
    load_clear();
    mem[0] = ins(4'h1, 4'd1, 4'd0, 4'd0, 16'h002A);
    mem[1] = ins(4'h9, 4'd0, 4'd1, 4'd0, 16'd0);
    mem[2] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    run_halt("p6_halt");
    nreq = reqq.size();
    nout = outq.size();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      en   = ~en;
      spur = (i % 2 == 0);
    end
    @(posedge clk); #2;
    spur = 1'b0;
    en   = 1'b0;
    chk("p6_no_req", reqq.size(), nreq);
    chk("p6_no_out", outq.size(), nout);
    chk("p6_halted", halted, 1'b1);
    chk("p6_reg", dut.r_regs[1], 8'h2A);
    chk("p6_io_out", io_out, 8'h2A);
    chk("p6_err", err, 1'b0);

    // Asynchronous reset from HALT, then reset mid-WAIT with a late response.
    rst = 1'b1;
    #1;
    chk("p7_async_halted", halted, 1'b0);
    chk("p7_async_io_out", io_out, 8'h00);
    @(posedge clk); #2;
    rst = 1'b0;
    clear_mon();
    load_clear();
    mem[0] = ins(4'h1, 4'd1, 4'd0, 4'd0, 16'h0055);
    lat = 5;
    en  = 1'b1;
    for (int n = 0; n < 20 && reqq.size() == 0; n++) @(posedge clk);
    #2;
    en = 1'b0;
    chk("p7_req_seen", reqq.size(), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("p7_rst_req", imem_req, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("p7_no_refetch", reqq.size(), 1);
    chk("p7_addr", imem_addr, 13'h0);
    clear_mon();
    lat    = 1;
    mem[0] = ins(4'h9, 4'd0, 4'd1, 4'd0, 16'd0);
    mem[1] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    run_halt("p7_halt");
    chk("p7_first_addr", aq(0), 0);
    chk("p7_reg_zero", oq(0), 0);
    chk("p7_err", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
